// File: rtl/controlador_frecuencias.sv
// Frequency-index controller: debounced up/down buttons select an index for an
// external divisor memory, and a three-state FSM turns the returned half-period into a square tone.
module controlador_frecuencias #(
  parameter logic [2:0] FRE_MAX = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        en,
  input  logic [10:0] fre_sel_in,
  output logic [2:0]  fre,
  output logic        tone,
  output logic        cambio
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  logic [2:0]  up_sync_q, up_sync_d;
  logic [2:0]  dn_sync_q, dn_sync_d;
  logic        up_arm_q, up_arm_d;
  logic        dn_arm_q, dn_arm_d;
  logic [1:0]  vld_q, vld_d;
  logic [2:0]  fre_q, fre_d;
  logic        cambio_q, cambio_d;
  logic        tone_q, tone_d;
  logic [10:0] cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic        up_pulse_s, dn_pulse_s;

  // A button only arms after the synchronized level has been seen low, so a level held across reset never fires.
  always_comb begin
    up_sync_d  = {up_sync_q[1:0], btn_up};
    dn_sync_d  = {dn_sync_q[1:0], btn_down};
    vld_d      = {vld_q[0], 1'b1};
    up_arm_d   = up_arm_q | (vld_q[1] & ~up_sync_q[1]);
    dn_arm_d   = dn_arm_q | (vld_q[1] & ~dn_sync_q[1]);
    up_pulse_s = up_sync_q[1] & ~up_sync_q[2] & up_arm_q;
    dn_pulse_s = dn_sync_q[1] & ~dn_sync_q[2] & dn_arm_q;
  end

  // Saturating index update; cambio flags only real changes.
  always_comb begin
    fre_d    = fre_q;
    cambio_d = 1'b0;
    if (up_pulse_s && !dn_pulse_s) begin
      if (fre_q != FRE_MAX) begin
        fre_d    = fre_q + 3'd1;
        cambio_d = 1'b1;
      end else begin
        fre_d    = fre_q;
      end
    end else if (dn_pulse_s && !up_pulse_s) begin
      if (fre_q != 3'd0) begin
        fre_d    = fre_q - 3'd1;
        cambio_d = 1'b1;
      end else begin
        fre_d    = fre_q;
      end
    end else begin
      fre_d = fre_q;
    end
  end

  // Tone generator FSM: en low dominates, then a fresh index forces a reload, then silence on a zero divisor.
  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      tone_d  = 1'b0;
      cnt_d   = 11'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = LOAD;
          tone_d  = 1'b0;
          cnt_d   = 11'd0;
        end
        LOAD, RUN: begin
          if (cambio_q) begin
            state_d = LOAD;
          end else if (fre_sel_in == 11'd0) begin
            state_d = RUN;
            tone_d  = 1'b0;
            cnt_d   = 11'd0;
          end else if (state_q == LOAD) begin
            state_d = RUN;
            cnt_d   = fre_sel_in;
          end else if (cnt_q != 11'd0) begin
            cnt_d   = cnt_q - 11'd1;
          end else begin
            tone_d  = ~tone_q;
            cnt_d   = fre_sel_in;
          end
        end
        default: begin
          state_d = IDLE;
          tone_d  = 1'b0;
          cnt_d   = 11'd0;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync_q <= 3'd0;
      dn_sync_q <= 3'd0;
      up_arm_q  <= 1'b0;
      dn_arm_q  <= 1'b0;
      vld_q     <= 2'd0;
      fre_q     <= 3'd0;
      cambio_q  <= 1'b0;
      tone_q    <= 1'b0;
      cnt_q     <= 11'd0;
      state_q   <= IDLE;
    end else begin
      up_sync_q <= up_sync_d;
      dn_sync_q <= dn_sync_d;
      up_arm_q  <= up_arm_d;
      dn_arm_q  <= dn_arm_d;
      vld_q     <= vld_d;
      fre_q     <= fre_d;
      cambio_q  <= cambio_d;
      tone_q    <= tone_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign fre    = fre_q;
  assign tone   = tone_q;
  assign cambio = cambio_q;

endmodule
